// File: rtl/mm_wb_buffer_if.sv
// Control, MXU-beat and RAM-write signals of the matrix-multiply writeback buffer.
// The slave modport is the buffer side; master is the job issuer / MXU / RAM side.
interface mm_wb_buffer_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 8
);
  logic              lsu_mm_wb_ctrl_vld;
  logic [3:0]        lsu_mm_wb_ctrl_row_len;
  logic [3:0]        lsu_mm_wb_ctrl_col_len;
  logic [ADDR_W-1:0] lsu_mm_wb_ctrl_start_addr;
  logic [15:0]       mxu_mm_wb_vld;
  logic [DATA_W-1:0] mxu_mm_wb_data;
  logic              lsu_mm_wb_mxu_rdy;
  logic              lsu_mm_wb_ram_write_vld;
  logic [ADDR_W-1:0] lsu_mm_wb_ram_write_addr;
  logic [DATA_W-1:0] lsu_mm_wb_ram_write_data;
  logic [15:0]       lsu_mm_wb_ram_write_mask;
  logic              lsu_mm_wb_ram_write_rdy;
  logic              lsu_mm_wb_busy;
  logic              lsu_mm_wb_done;

  modport master (
    output lsu_mm_wb_ctrl_vld, lsu_mm_wb_ctrl_row_len, lsu_mm_wb_ctrl_col_len,
    output lsu_mm_wb_ctrl_start_addr, mxu_mm_wb_vld, mxu_mm_wb_data, lsu_mm_wb_ram_write_rdy,
    input  lsu_mm_wb_mxu_rdy, lsu_mm_wb_ram_write_vld, lsu_mm_wb_ram_write_addr,
    input  lsu_mm_wb_ram_write_data, lsu_mm_wb_ram_write_mask, lsu_mm_wb_busy, lsu_mm_wb_done
  );

  modport slave (
    input  lsu_mm_wb_ctrl_vld, lsu_mm_wb_ctrl_row_len, lsu_mm_wb_ctrl_col_len,
    input  lsu_mm_wb_ctrl_start_addr, mxu_mm_wb_vld, mxu_mm_wb_data, lsu_mm_wb_ram_write_rdy,
    output lsu_mm_wb_mxu_rdy, lsu_mm_wb_ram_write_vld, lsu_mm_wb_ram_write_addr,
    output lsu_mm_wb_ram_write_data, lsu_mm_wb_ram_write_mask, lsu_mm_wb_busy, lsu_mm_wb_done
  );
endinterface

// File: rtl/mm_wb_buffer.sv
// Matrix-multiply writeback buffer: queues MXU result rows in a small FIFO and drains them
// as one masked LSU RAM write per row, starting at the job's start address.
module mm_wb_buffer #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input logic           clk,
  input logic           rst,
  mm_wb_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        row_len_q, col_len_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [4:0]        acc_cnt_q;
  logic [3:0]        wr_cnt_q;
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic fifo_empty, fifo_full;
  logic start, push, pop, last_write;
  logic mxu_rdy, write_vld;
  logic [15:0] col_mask;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign start      = (state_q == StIdle) && bus.lsu_mm_wb_ctrl_vld;
  assign mxu_rdy    = (state_q == StRun) && !fifo_full && (acc_cnt_q <= {1'b0, row_len_q});
  assign write_vld  = (state_q == StRun) && !fifo_empty;
  assign push       = (|bus.mxu_mm_wb_vld) && mxu_rdy;
  assign pop        = write_vld && bus.lsu_mm_wb_ram_write_rdy;
  assign last_write = pop && (wr_cnt_q == row_len_q);

  always_comb begin
    col_mask = '0;
    for (int i = 0; i < 16; i++) begin
      col_mask[i] = (4'(i) <= col_len_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.lsu_mm_wb_ctrl_vld) state_d = StRun;
      StRun:   if (last_write) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      row_len_q    <= '0;
      col_len_q    <= '0;
      start_addr_q <= '0;
      acc_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        row_len_q    <= bus.lsu_mm_wb_ctrl_row_len;
        col_len_q    <= bus.lsu_mm_wb_ctrl_col_len;
        start_addr_q <= bus.lsu_mm_wb_ctrl_start_addr;
        acc_cnt_q    <= '0;
        wr_cnt_q     <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
      end else begin
        if (push) begin
          wr_ptr_q  <= wr_ptr_q + 1'b1;
          acc_cnt_q <= acc_cnt_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
    end
  end

  // Row storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= bus.mxu_mm_wb_data;
    end
  end

  assign bus.lsu_mm_wb_mxu_rdy        = mxu_rdy;
  assign bus.lsu_mm_wb_ram_write_vld  = write_vld;
  assign bus.lsu_mm_wb_ram_write_addr = write_vld ? start_addr_q + ADDR_W'(wr_cnt_q) : '0;
  assign bus.lsu_mm_wb_ram_write_data = write_vld ? mem_q[rd_ptr_q[PtrW-1:0]] : '0;
  assign bus.lsu_mm_wb_ram_write_mask = write_vld ? col_mask : '0;
  assign bus.lsu_mm_wb_busy           = (state_q == StRun);
  assign bus.lsu_mm_wb_done           = (state_q == StDone);

endmodule

// File: tb/tb_mm_wb_buffer.sv
// Directed self-checking bench for mm_wb_buffer: single row, streaming, backpressure,
// address wrap, ignored mid-job control and mid-job reset.
module tb_mm_wb_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mm_wb_buffer_if #(.DATA_W(128), .ADDR_W(8)) bus ();

  mm_wb_buffer #(.DATA_W(128), .ADDR_W(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] row_pat(int k);
    return {16{8'(8'h30 + k)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a job from the current (idle) cycle; returns at the first RUN cycle.
  task automatic start_job(logic [3:0] row_len, logic [3:0] col_len, logic [7:0] addr);
    bus.lsu_mm_wb_ctrl_vld        = 1'b1;
    bus.lsu_mm_wb_ctrl_row_len    = row_len;
    bus.lsu_mm_wb_ctrl_col_len    = col_len;
    bus.lsu_mm_wb_ctrl_start_addr = addr;
    tick();
    bus.lsu_mm_wb_ctrl_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (bus.lsu_mm_wb_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", bus.lsu_mm_wb_busy); end
    checks++; if (bus.lsu_mm_wb_done !== 1'b0) begin errors++;
      $display("FAIL reset_done: got %b want 0", bus.lsu_mm_wb_done); end
    checks++; if (bus.lsu_mm_wb_mxu_rdy !== 1'b0) begin errors++;
      $display("FAIL reset_mxu_rdy: got %b want 0", bus.lsu_mm_wb_mxu_rdy); end
    checks++; if (bus.lsu_mm_wb_ram_write_vld !== 1'b0) begin errors++;
      $display("FAIL reset_write_vld: got %b want 0", bus.lsu_mm_wb_ram_write_vld); end
    checks++; if (bus.lsu_mm_wb_ram_write_mask !== 16'h0) begin errors++;
      $display("FAIL reset_mask: got %h want 0000", bus.lsu_mm_wb_ram_write_mask); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_row();
    start_job(4'd0, 4'd15, 8'h10);
    bus.lsu_mm_wb_ram_write_rdy = 1'b1;
    bus.mxu_mm_wb_vld  = 16'h0001;
    bus.mxu_mm_wb_data = {16{8'hA5}};
    @(negedge clk);
    checks++; if (bus.lsu_mm_wb_busy !== 1'b1) begin errors++;
      $display("FAIL single_busy: got %b want 1", bus.lsu_mm_wb_busy); end
    checks++; if (bus.lsu_mm_wb_mxu_rdy !== 1'b1) begin errors++;
      $display("FAIL single_rdy: got %b want 1", bus.lsu_mm_wb_mxu_rdy); end
    checks++; if (bus.lsu_mm_wb_ram_write_vld !== 1'b0) begin errors++;
      $display("FAIL single_early_vld: got %b want 0", bus.lsu_mm_wb_ram_write_vld); end
    tick();
    bus.mxu_mm_wb_vld = 16'h0;
    @(negedge clk);
    checks++; if (bus.lsu_mm_wb_ram_write_vld !== 1'b1) begin errors++;
      $display("FAIL single_vld: got %b want 1", bus.lsu_mm_wb_ram_write_vld); end
    checks++; if (bus.lsu_mm_wb_ram_write_addr !== 8'h10) begin errors++;
      $display("FAIL single_addr: got %h want 10", bus.lsu_mm_wb_ram_write_addr); end
    checks++; if (bus.lsu_mm_wb_ram_write_mask !== 16'hFFFF) begin errors++;
      $display("FAIL single_mask: got %h want ffff", bus.lsu_mm_wb_ram_write_mask); end
    checks++; if (bus.lsu_mm_wb_ram_write_data !== {16{8'hA5}}) begin errors++;
      $display("FAIL single_data: got %h want %h", bus.lsu_mm_wb_ram_write_data, {16{8'hA5}}); end
    checks++; if (bus.lsu_mm_wb_mxu_rdy !== 1'b0) begin errors++;
      $display("FAIL single_rdy_drop: got %b want 0", bus.lsu_mm_wb_mxu_rdy); end
    tick();
    @(negedge clk);
    checks++; if (bus.lsu_mm_wb_done !== 1'b1) begin errors++;
      $display("FAIL single_done: got %b want 1", bus.lsu_mm_wb_done); end
    checks++; if (bus.lsu_mm_wb_busy !== 1'b0) begin errors++;
      $display("FAIL single_busy_done: got %b want 0", bus.lsu_mm_wb_busy); end
    tick();
    @(negedge clk);
    checks++; if (bus.lsu_mm_wb_done !== 1'b0) begin errors++;
      $display("FAIL single_done_pulse: got %b want 0", bus.lsu_mm_wb_done); end
    tick();
  endtask

  task automatic test_streaming();
    int done_cnt = 0;
    start_job(4'd15, 4'd7, 8'h00);
    bus.lsu_mm_wb_ram_write_rdy = 1'b1;
    for (int k = 0; k < 19; k++) begin
      bus.mxu_mm_wb_vld  = (k < 16) ? 16'hFFFF : 16'h0;
      bus.mxu_mm_wb_data = row_pat(k);
      @(negedge clk);
      if (k <= 16) begin
        checks++; if (bus.lsu_mm_wb_mxu_rdy !== 1'(k < 16)) begin errors++;
          $display("FAIL stream_rdy[%0d]: got %b want %b", k, bus.lsu_mm_wb_mxu_rdy, k < 16); end
      end
      if (k >= 1 && k <= 16) begin
        checks++; if (bus.lsu_mm_wb_ram_write_vld !== 1'b1) begin errors++;
          $display("FAIL stream_vld[%0d]: got %b want 1", k, bus.lsu_mm_wb_ram_write_vld); end
        checks++; if (bus.lsu_mm_wb_ram_write_addr !== 8'(k - 1)) begin errors++;
          $display("FAIL stream_addr[%0d]: got %h want %h", k, bus.lsu_mm_wb_ram_write_addr,
                   8'(k - 1)); end
        checks++; if (bus.lsu_mm_wb_ram_write_data !== row_pat(k - 1)) begin errors++;
          $display("FAIL stream_data[%0d]: got %h want %h", k, bus.lsu_mm_wb_ram_write_data,
                   row_pat(k - 1)); end
        checks++; if (bus.lsu_mm_wb_ram_write_mask !== 16'h00FF) begin errors++;
          $display("FAIL stream_mask[%0d]: got %h want 00ff", k, bus.lsu_mm_wb_ram_write_mask); end
      end
      if (bus.lsu_mm_wb_done === 1'b1) begin
        done_cnt++;
        checks++; if (k != 17) begin errors++;
          $display("FAIL stream_done_cycle: got %0d want 17", k); end
      end
      tick();
    end
    checks++; if (done_cnt != 1) begin errors++;
      $display("FAIL stream_done_count: got %0d want 1", done_cnt); end
    bus.mxu_mm_wb_vld = 16'h0;
  endtask

  task automatic test_backpressure();
    int b = 0;
    int n = 0;
    int done_cnt = 0;
    start_job(4'd7, 4'd3, 8'h20);
    for (int k = 0; k < 40; k++) begin
      bus.lsu_mm_wb_ram_write_rdy = (k >= 10);
      bus.mxu_mm_wb_vld  = (b < 8) ? 16'h8000 : 16'h0;
      bus.mxu_mm_wb_data = row_pat(64 + b);
      @(negedge clk);
      if (k == 4) begin
        checks++; if (bus.lsu_mm_wb_mxu_rdy !== 1'b0) begin errors++;
          $display("FAIL bp_full_rdy: got %b want 0", bus.lsu_mm_wb_mxu_rdy); end
      end
      if (k >= 1 && k <= 9) begin
        checks++; if (bus.lsu_mm_wb_ram_write_vld !== 1'b1 ||
                      bus.lsu_mm_wb_ram_write_addr !== 8'h20 ||
                      bus.lsu_mm_wb_ram_write_data !== row_pat(64)) begin errors++;
          $display("FAIL bp_hold[%0d]: got vld=%b addr=%h data=%h want 1 20 %h", k,
                   bus.lsu_mm_wb_ram_write_vld, bus.lsu_mm_wb_ram_write_addr,
                   bus.lsu_mm_wb_ram_write_data, row_pat(64)); end
      end
      if (k == 9) begin
        checks++; if (b != 4) begin errors++;
          $display("FAIL bp_accepted: got %0d want 4", b); end
      end
      if (bus.lsu_mm_wb_ram_write_vld === 1'b1 && bus.lsu_mm_wb_ram_write_rdy === 1'b1) begin
        checks++; if (bus.lsu_mm_wb_ram_write_addr !== 8'(8'h20 + n) ||
                      bus.lsu_mm_wb_ram_write_data !== row_pat(64 + n) ||
                      bus.lsu_mm_wb_ram_write_mask !== 16'h000F) begin errors++;
          $display("FAIL bp_write[%0d]: got addr=%h mask=%h data=%h want %h 000f %h", n,
                   bus.lsu_mm_wb_ram_write_addr, bus.lsu_mm_wb_ram_write_mask,
                   bus.lsu_mm_wb_ram_write_data, 8'(8'h20 + n), row_pat(64 + n)); end
        n++;
      end
      if (bus.lsu_mm_wb_mxu_rdy === 1'b1 && bus.mxu_mm_wb_vld != 16'h0) b++;
      if (bus.lsu_mm_wb_done === 1'b1) done_cnt++;
      tick();
    end
    checks++; if (n != 8) begin errors++; $display("FAIL bp_write_count: got %0d want 8", n); end
    checks++; if (b != 8) begin errors++; $display("FAIL bp_beat_count: got %0d want 8", b); end
    checks++; if (done_cnt != 1) begin errors++;
      $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    bus.mxu_mm_wb_vld = 16'h0;
  endtask

  task automatic test_wrap();
    start_job(4'd3, 4'd15, 8'hFE);
    bus.lsu_mm_wb_ram_write_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.mxu_mm_wb_vld  = (k < 4) ? 16'h0010 : 16'h0;
      bus.mxu_mm_wb_data = row_pat(16 + k);
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        checks++; if (bus.lsu_mm_wb_ram_write_vld !== 1'b1 ||
                      bus.lsu_mm_wb_ram_write_addr !== 8'(8'hFE + k - 1)) begin errors++;
          $display("FAIL wrap_addr[%0d]: got vld=%b addr=%h want 1 %h", k,
                   bus.lsu_mm_wb_ram_write_vld, bus.lsu_mm_wb_ram_write_addr,
                   8'(8'hFE + k - 1)); end
      end
      if (k == 5) begin
        checks++; if (bus.lsu_mm_wb_done !== 1'b1) begin errors++;
          $display("FAIL wrap_done: got %b want 1", bus.lsu_mm_wb_done); end
      end
      tick();
    end
  endtask

  task automatic test_ignore_and_reset();
    start_job(4'd5, 4'd15, 8'h80);
    bus.lsu_mm_wb_ram_write_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.lsu_mm_wb_ctrl_vld        = (k == 0);
      bus.lsu_mm_wb_ctrl_row_len    = 4'd0;
      bus.lsu_mm_wb_ctrl_col_len    = 4'd0;
      bus.lsu_mm_wb_ctrl_start_addr = 8'h40;
      bus.mxu_mm_wb_vld  = 16'h0100;
      bus.mxu_mm_wb_data = row_pat(32 + k);
      @(negedge clk);
      if (k >= 1) begin
        checks++; if (bus.lsu_mm_wb_ram_write_addr !== 8'(8'h80 + k - 1) ||
                      bus.lsu_mm_wb_ram_write_mask !== 16'hFFFF) begin errors++;
          $display("FAIL ignore_ctrl[%0d]: got addr=%h mask=%h want %h ffff", k,
                   bus.lsu_mm_wb_ram_write_addr, bus.lsu_mm_wb_ram_write_mask,
                   8'(8'h80 + k - 1)); end
        checks++; if (bus.lsu_mm_wb_mxu_rdy !== 1'b1) begin errors++;
          $display("FAIL ignore_rdy[%0d]: got %b want 1", k, bus.lsu_mm_wb_mxu_rdy); end
      end
      tick();
    end
    rst = 1'b1;
    bus.lsu_mm_wb_ram_write_rdy = 1'b0;
    bus.mxu_mm_wb_vld = 16'h0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.lsu_mm_wb_busy !== 1'b0 || bus.lsu_mm_wb_ram_write_vld !== 1'b0 ||
                  bus.lsu_mm_wb_mxu_rdy !== 1'b0 || bus.lsu_mm_wb_done !== 1'b0) begin errors++;
      $display("FAIL midjob_reset: got busy=%b vld=%b rdy=%b done=%b want 0 0 0 0",
               bus.lsu_mm_wb_busy, bus.lsu_mm_wb_ram_write_vld, bus.lsu_mm_wb_mxu_rdy,
               bus.lsu_mm_wb_done); end
    tick();
    @(negedge clk);
    checks++; if (bus.lsu_mm_wb_done !== 1'b0 || bus.lsu_mm_wb_busy !== 1'b0) begin errors++;
      $display("FAIL reset_no_done: got done=%b busy=%b want 0 0",
               bus.lsu_mm_wb_done, bus.lsu_mm_wb_busy); end
    tick();
    start_job(4'd1, 4'd0, 8'h05);
    bus.lsu_mm_wb_ram_write_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mxu_mm_wb_vld  = (k < 2) ? 16'h0002 : 16'h0;
      bus.mxu_mm_wb_data = row_pat(100 + k);
      @(negedge clk);
      if (k >= 1 && k <= 2) begin
        checks++; if (bus.lsu_mm_wb_ram_write_addr !== 8'(8'h05 + k - 1) ||
                      bus.lsu_mm_wb_ram_write_data !== row_pat(100 + k - 1) ||
                      bus.lsu_mm_wb_ram_write_mask !== 16'h0001) begin errors++;
          $display("FAIL rerun_write[%0d]: got addr=%h mask=%h data=%h want %h 0001 %h", k,
                   bus.lsu_mm_wb_ram_write_addr, bus.lsu_mm_wb_ram_write_mask,
                   bus.lsu_mm_wb_ram_write_data, 8'(8'h05 + k - 1), row_pat(100 + k - 1)); end
      end
      if (k == 3) begin
        checks++; if (bus.lsu_mm_wb_done !== 1'b1) begin errors++;
          $display("FAIL rerun_done: got %b want 1", bus.lsu_mm_wb_done); end
      end
      tick();
    end
  endtask

  initial begin
    bus.lsu_mm_wb_ctrl_vld        = 1'b0;
    bus.lsu_mm_wb_ctrl_row_len    = 4'd0;
    bus.lsu_mm_wb_ctrl_col_len    = 4'd0;
    bus.lsu_mm_wb_ctrl_start_addr = 8'h00;
    bus.mxu_mm_wb_vld             = 16'h0;
    bus.mxu_mm_wb_data            = '0;
    bus.lsu_mm_wb_ram_write_rdy   = 1'b0;
    test_reset();
    test_single_row();
    test_streaming();
    tick();
    test_backpressure();
    tick();
    test_wrap();
    tick();
    test_ignore_and_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_wb_buffer.md
Name: mm_wb_buffer

Overview:
- Writeback counterpart of the matrix-multiply operand buffer: collects result rows from the MXU and writes them back into the LSU RAM.
- A control pulse supplies the number of rows, the number of active columns and the RAM start row address.
- Each MXU beat is one 16-byte row. It is queued in a small FIFO and drained as one RAM write per row, with byte enables derived from the column count.

Parameters:
- DATA_W, 128, row data width (16 lanes x 8 bits).
- ADDR_W, 8, RAM row address width.
- DEPTH, 4, row FIFO depth (power of two, at least 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- lsu_mm_wb_ctrl_vld  input  1  start pulse for one writeback job
- lsu_mm_wb_ctrl_row_len  input  4  rows minus 1 (0 means 1 row, 15 means 16 rows)
- lsu_mm_wb_ctrl_col_len  input  4  active columns minus 1
- lsu_mm_wb_ctrl_start_addr  input  ADDR_W  RAM row address of row 0
- mxu_mm_wb_vld  input  16  per-lane valid; the beat is present when any bit is set
- mxu_mm_wb_data  input  DATA_W  result row; lane i is bits [8i+7:8i]
- lsu_mm_wb_mxu_rdy  output  1  buffer can accept a beat
- lsu_mm_wb_ram_write_vld  output  1  RAM write request
- lsu_mm_wb_ram_write_addr  output  ADDR_W  RAM write row address
- lsu_mm_wb_ram_write_data  output  DATA_W  RAM write data
- lsu_mm_wb_ram_write_mask  output  16  byte enables
- lsu_mm_wb_ram_write_rdy  input  1  RAM accepts the write
- lsu_mm_wb_busy  output  1  job in progress
- lsu_mm_wb_done  output  1  one-cycle pulse when the job completes

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset effect: state returns to IDLE; FIFO pointers, accept counter and write counter clear; stored job fields clear. All outputs read 0 the cycle after rst is sampled high, including mid-job. Queued rows are discarded and no done pulse is produced.
- States:
  - IDLE: waits for a job.
  - RUN: collects beats and drains writes.
  - DONE: lasts exactly one cycle.
- IDLE -> RUN: on lsu_mm_wb_ctrl_vld, latch row_len, col_len and start_addr, clear both counters, busy=1 the next cycle. ctrl_vld is ignored in RUN and DONE.
- Beat accept: a beat is accepted when |mxu_mm_wb_vld && lsu_mm_wb_mxu_rdy.
  - lsu_mm_wb_mxu_rdy = (state==RUN) && !fifo_full && (acc_cnt <= row_len).
  - acc_cnt is 5 bits, so rdy drops permanently after row_len+1 beats.
  - A push at full is impossible: rdy is low when full, even if a pop happens the same cycle (accepted one-cycle bubble).
  - Beats offered while rdy=0 are not consumed; the MXU must hold them.
- Write port:
  - ram_write_vld = !fifo_empty in RUN.
  - data = FIFO head.
  - addr = start_addr + wr_cnt, modulo 2^ADDR_W (wraps 255 -> 0).
  - mask bit i = (i <= col_len), e.g. col_len=3 gives 16'h000F.
  - Pop and wr_cnt+1 happen on vld && rdy.
  - vld, addr, data and mask are held stable while rdy=0.
- Latency: a beat accepted in cycle N appears on the write port in cycle N+1 (registered FIFO). Back-to-back beats with rdy=1 give one write per cycle.
- Completion:
  - The write handshake with wr_cnt==row_len moves the state to DONE.
  - In the DONE cycle: done=1, busy=0.
  - The next cycle returns to IDLE, where a new ctrl_vld is accepted.
- Simultaneous push and pop: both allowed in the same cycle; occupancy is unchanged.
- Lane valids: only the OR of mxu_mm_wb_vld is used. The mask comes from col_len, not from the lane valids.
- Not supported: job abort; only rst cancels a job.

Test Plan:
- Single row: ctrl row_len=0, col_len=15, addr=8'h10; one beat with data 128'hA5.., ram_write_rdy=1 -> one write at addr 8'h10 the cycle after the beat, mask 16'hFFFF; done pulse the following cycle; busy 1 -> 0.
- Streaming: row_len=15, col_len=7, addr=8'h00; 16 consecutive beats, rdy=1 -> 16 writes at addresses 0..15, mask 16'h00FF, data in order; rdy low after the 16th beat; exactly one done.
- Backpressure: row_len=7, ram_write_rdy=0 for 10 cycles -> 4 beats accepted, then mxu_rdy=0 with the head write held stable; after release, 8 writes in order with no loss or duplication.
- Wrap: addr=8'hFE, row_len=3 -> writes at FE, FF, 00, 01.
- Ignore and reset: a second ctrl_vld mid-job is ignored (addresses unchanged). rst asserted after 2 of 6 writes -> next cycle busy=0, write_vld=0, mxu_rdy=0, no done; a new job then runs cleanly from its own start_addr.
